action_sampler: RTL and testbench



---
 rtl/action_sampler.sv | 107 ++++++++++
 tb/tb_action_sampler.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/action_sampler.sv
// action_sampler: edge-detected button presses to atomic turn action pairs; ACTION_SAMPLER_TIMEOUT_EN forces absent players to wait
module action_sampler #(
  parameter int TURN_CYCLES = 1000,
  parameter int CNT_W = $clog2(TURN_CYCLES)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] p1_btn,
  input  logic [5:0] p2_btn,
  input  logic       turn_ready,
  output logic [2:0] action1,
  output logic [2:0] action2,
  output logic       turn_valid,
  output logic       p1_locked,
  output logic       p2_locked,
  output logic [7:0] turn_count
);
  typedef enum logic {COLLECT, ISSUE} state_t;
  state_t state_q, state_d;
  logic [5:0] p1_btn_q, p2_btn_q, p1_press, p2_press;
  logic armed_q;
  logic [2:0] a1_q, a1_d, a2_q, a2_d;
  logic l1_q, l1_d, l2_q, l2_d;
  logic [7:0] cnt_q, cnt_d;
  logic fire, timeout;

  function automatic logic [2:0] enc(input logic [5:0] p);
    return p[0] ? 3'b000 : p[1] ? 3'b001 : p[3] ? 3'b011 :
           p[4] ? 3'b100 : p[5] ? 3'b101 : 3'b010;
  endfunction

  always_ff @(posedge clk) begin
    p1_btn_q <= rst ? '0 : p1_btn;
    p2_btn_q <= rst ? '0 : p2_btn;
    armed_q  <= !rst;
  end

  assign p1_press = armed_q ? p1_btn & ~p1_btn_q : '0;
  assign p2_press = armed_q ? p2_btn & ~p2_btn_q : '0;
  assign fire = state_q == ISSUE && turn_ready;

`ifdef ACTION_SAMPLER_TIMEOUT_EN
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  assign tcnt_d = state_q == COLLECT ? tcnt_q + 1'b1 : '0;
  assign timeout = state_q == COLLECT && tcnt_q == CNT_W'(TURN_CYCLES - 1);
  always_ff @(posedge clk) begin
    tcnt_q <= rst ? '0 : tcnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    state_q <= rst ? COLLECT : state_d;
  end

  always_comb begin
    state_d = state_q == COLLECT ? ((l1_q && l2_q) || timeout ? ISSUE : COLLECT)
                                 : (fire ? COLLECT : ISSUE);
  end

  always_comb begin
    l1_d  = l1_q;
    l2_d  = l2_q;
    a1_d  = a1_q;
    a2_d  = a2_q;
    cnt_d = cnt_q + {7'd0, fire};
    if (fire) begin
      l1_d = 1'b0;
      l2_d = 1'b0;
    end else if (state_q == COLLECT) begin
      if (!l1_q && (|p1_press || timeout)) begin
        l1_d = 1'b1;
        a1_d = enc(p1_press);
      end
      if (!l2_q && (|p2_press || timeout)) begin
        l2_d = 1'b1;
        a2_d = enc(p2_press);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      l1_q  <= 1'b0;
      l2_q  <= 1'b0;
      a1_q  <= 3'b010;
      a2_q  <= 3'b010;
      cnt_q <= '0;
    end else begin
      l1_q  <= l1_d;
      l2_q  <= l2_d;
      a1_q  <= a1_d;
      a2_q  <= a2_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    turn_valid = state_q == ISSUE;
    action1    = a1_q;
    action2    = a2_q;
    p1_locked  = l1_q;
    p2_locked  = l2_q;
    turn_count = cnt_q;
  end
endmodule

// File: tb/tb_action_sampler.sv
// tb_action_sampler: directed self-checking bench for action_sampler
module tb_action_sampler;
  logic clk = 1'b0, rst = 1'b1, turn_ready = 1'b0;
  logic [5:0] p1_btn = '0, p2_btn = '0;
  logic [2:0] action1, action2;
  logic turn_valid, p1_locked, p2_locked;
  logic [7:0] turn_count;
  int checks = 0, failures = 0;

  action_sampler #(.TURN_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .p1_btn(p1_btn), .p2_btn(p2_btn), .turn_ready(turn_ready),
    .action1(action1), .action2(action2), .turn_valid(turn_valid),
    .p1_locked(p1_locked), .p2_locked(p2_locked), .turn_count(turn_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; p1_btn = 6'h3f; p2_btn = 6'h3f; turn_ready = 1'b0;
    tick; tick;
    checks++; if ({turn_valid, p1_locked, p2_locked} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {turn_valid, p1_locked, p2_locked}); end
    checks++; if ({action1, action2} !== 6'b010_010) begin failures++; $display("FAIL reset_actions got=%b exp=010010", {action1, action2}); end
    checks++; if (turn_count !== 8'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", turn_count); end
    rst = 1'b0;
    tick; tick; tick;
    checks++; if ({p1_locked, p2_locked} !== 2'b00) begin failures++; $display("FAIL reset_held_no_press got=%b exp=00", {p1_locked, p2_locked}); end
    p1_btn = '0; p2_btn = '0;
    tick;
  endtask

  task automatic test_basic;
    rst = 1'b1; tick; rst = 1'b0; tick;
    turn_ready = 1'b1;
    p1_btn = 6'b100000; tick;
    checks++; if ({p1_locked, p2_locked} !== 2'b10) begin failures++; $display("FAIL basic_p1_lock got=%b exp=10", {p1_locked, p2_locked}); end
    p1_btn = '0; tick; tick; tick;
    p2_btn = 6'b000001; tick;
    checks++; if ({turn_valid, p2_locked} !== 2'b01) begin failures++; $display("FAIL basic_p2_lock got=%b exp=01", {turn_valid, p2_locked}); end
    p2_btn = '0; tick;
    checks++; if ({turn_valid, action1, action2} !== {1'b1, 3'b101, 3'b000}) begin failures++; $display("FAIL basic_issue got=%b exp=1101000", {turn_valid, action1, action2}); end
    tick;
    checks++; if ({turn_valid, p1_locked, p2_locked, turn_count} !== {3'b000, 8'd1}) begin failures++; $display("FAIL basic_done got=%b/%0d exp=000/1", {turn_valid, p1_locked, p2_locked}, turn_count); end
  endtask

  task automatic test_priority;
    turn_ready = 1'b0;
    p1_btn = 6'b000011; tick;
    checks++; if ({p1_locked, action1} !== {1'b1, 3'b000}) begin failures++; $display("FAIL prio_kick got=%b exp=1000", {p1_locked, action1}); end
    p1_btn = 6'b010011; tick;
    checks++; if (action1 !== 3'b000) begin failures++; $display("FAIL prio_lockout got=%b exp=000", action1); end
    p1_btn = '0; p2_btn = 6'b001000; tick;
    p2_btn = '0; tick;
    checks++; if ({turn_valid, action1, action2} !== {1'b1, 3'b000, 3'b011}) begin failures++; $display("FAIL prio_issue got=%b exp=1000011", {turn_valid, action1, action2}); end
  endtask

  task automatic test_backpressure;
    for (int i = 0; i < 20; i++) begin
      p1_btn = i[0] ? 6'h3f : 6'h00;
      p2_btn = i[0] ? 6'h00 : 6'h3f;
      tick;
      checks++; if ({turn_valid, action1, action2} !== {1'b1, 3'b000, 3'b011}) begin failures++; $display("FAIL bp_hold_%0d got=%b exp=1000011", i, {turn_valid, action1, action2}); end
    end
    p1_btn = '0; p2_btn = '0;
    checks++; if (turn_count !== 8'd1) begin failures++; $display("FAIL bp_count_before got=%0d exp=1", turn_count); end
    turn_ready = 1'b1; tick;
    checks++; if ({turn_valid, p1_locked, p2_locked, turn_count} !== {3'b000, 8'd2}) begin failures++; $display("FAIL bp_handshake got=%b/%0d exp=000/2", {turn_valid, p1_locked, p2_locked}, turn_count); end
  endtask

  task automatic test_back_to_back;
    p1_btn = 6'b010000; p2_btn = 6'b100000; tick;
    checks++; if ({turn_valid, p1_locked, p2_locked} !== 3'b011) begin failures++; $display("FAIL b2b_locks got=%b exp=011", {turn_valid, p1_locked, p2_locked}); end
    p1_btn = '0; p2_btn = '0; tick;
    checks++; if ({turn_valid, action1, action2} !== {1'b1, 3'b100, 3'b101}) begin failures++; $display("FAIL b2b_issue1 got=%b exp=1100101", {turn_valid, action1, action2}); end
    tick;
    checks++; if ({turn_valid, p1_locked, p2_locked, turn_count} !== {3'b000, 8'd3}) begin failures++; $display("FAIL b2b_done1 got=%b/%0d exp=000/3", {turn_valid, p1_locked, p2_locked}, turn_count); end
    p1_btn = 6'b000001; p2_btn = 6'b000010; tick;
    checks++; if ({p1_locked, p2_locked} !== 2'b11) begin failures++; $display("FAIL b2b_relock got=%b exp=11", {p1_locked, p2_locked}); end
    p1_btn = '0; p2_btn = '0; tick;
    checks++; if ({turn_valid, action1, action2} !== {1'b1, 3'b000, 3'b001}) begin failures++; $display("FAIL b2b_issue2 got=%b exp=1000001", {turn_valid, action1, action2}); end
    tick;
    checks++; if ({turn_valid, turn_count} !== {1'b0, 8'd4}) begin failures++; $display("FAIL b2b_done2 got=%b/%0d exp=0/4", turn_valid, turn_count); end
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 251; i++) begin
      p1_btn = 6'b000001; p2_btn = 6'b000001; tick;
      p1_btn = '0; p2_btn = '0; tick; tick;
    end
    checks++; if (turn_count !== 8'd255) begin failures++; $display("FAIL wrap_255 got=%0d exp=255", turn_count); end
    p1_btn = 6'b000001; p2_btn = 6'b000001; tick;
    p1_btn = '0; p2_btn = '0; tick; tick;
    checks++; if (turn_count !== 8'd0) begin failures++; $display("FAIL wrap_0 got=%0d exp=0", turn_count); end
  endtask

  task automatic test_reset_mid;
    turn_ready = 1'b0;
    p1_btn = 6'b000100; p2_btn = 6'b100000; tick;
    p1_btn = '0; p2_btn = '0; tick;
    checks++; if ({turn_valid, action1, action2} !== {1'b1, 3'b010, 3'b101}) begin failures++; $display("FAIL mid_issue got=%b exp=1010101", {turn_valid, action1, action2}); end
    rst = 1'b1; tick;
    checks++; if ({turn_valid, p1_locked, p2_locked, turn_count} !== {3'b000, 8'd0}) begin failures++; $display("FAIL mid_reset got=%b/%0d exp=000/0", {turn_valid, p1_locked, p2_locked}, turn_count); end
    checks++; if ({action1, action2} !== 6'b010_010) begin failures++; $display("FAIL mid_reset_actions got=%b exp=010010", {action1, action2}); end
    rst = 1'b0; tick;
  endtask

`ifdef ACTION_SAMPLER_TIMEOUT_EN
  task automatic test_timeout;
    turn_ready = 1'b0;
    rst = 1'b1; tick; rst = 1'b0;
    tick;
    p2_btn = 6'b001000; tick;
    p2_btn = '0;
    checks++; if ({p1_locked, p2_locked} !== 2'b01) begin failures++; $display("FAIL to_p2_lock got=%b exp=01", {p1_locked, p2_locked}); end
    repeat (5) tick;
    checks++; if ({turn_valid, p1_locked} !== 2'b00) begin failures++; $display("FAIL to_before got=%b exp=00", {turn_valid, p1_locked}); end
    tick;
    checks++; if ({turn_valid, action1, action2} !== {1'b1, 3'b010, 3'b011}) begin failures++; $display("FAIL to_forced got=%b exp=1010011", {turn_valid, action1, action2}); end
    turn_ready = 1'b1; tick;
    turn_ready = 1'b0;
    checks++; if ({turn_valid, turn_count} !== {1'b0, 8'd1}) begin failures++; $display("FAIL to_handshake got=%b/%0d exp=0/1", turn_valid, turn_count); end
    repeat (6) tick;
    checks++; if ({turn_valid, p1_locked, p2_locked} !== 3'b000) begin failures++; $display("FAIL to_before2 got=%b exp=000", {turn_valid, p1_locked, p2_locked}); end
    tick;
    p1_btn = 6'b000010; tick;
    p1_btn = '0;
    checks++; if ({turn_valid, action1, action2} !== {1'b1, 3'b001, 3'b010}) begin failures++; $display("FAIL to_press_wins got=%b exp=1001010", {turn_valid, action1, action2}); end
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_priority;
    test_backpressure;
    test_back_to_back;
    test_wrap;
    test_reset_mid;
`ifdef ACTION_SAMPLER_TIMEOUT_EN
    test_timeout;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
